trivium_stream_core: RTL
========================

// Module: trivium_stream_core
// PURPOSE
//  Parametrised Trivium keystream engine producing W keystream bits per clock, W >= 1.
//  - Loads an 80-bit key and an 80-bit IV, then runs the 1152-round warm-up.
//  - Afterwards it streams W-bit words over a valid/ready interface with no length limit.
//  - Optionally XORs an input data stream, acting as an encrypt/decrypt datapath.
//  Sits between the host key/IV register block and the cipher data FIFOs.
// PARAMETERS
//  W         8     keystream bits per cycle; legal values 1,2,4,8,16,32,64; any other value is an elaboration $error
//  INIT_RND  1152  warm-up rounds; must be a multiple of W
// PORTS
//  CLK       in   1    system clock; the only clock
//  RST       in   1    synchronous reset, active-high
//  EN        in   1    clock enable; when 0, every register holds its value
//  Kin       in   80   key, byte-ordered as the host bus presents it
//  Din       in   80   IV, same byte order as Kin
//  cfg_vld   in   1    Kin/Din valid
//  cfg_rdy   out  1    key/IV load accepted this cycle when cfg_vld & cfg_rdy
//  din       in   W    data to encrypt/decrypt (TRIVIUM_XOR_EN only)
//  din_vld   in   1    din valid
//  din_rdy   out  1    din consumed when din_vld & din_rdy
//  dout      out  W    keystream, or keystream ^ din
//  dout_vld  out  1    dout valid
//  dout_rdy  in   1    sink accepts dout
//  BSY       out  1    high while in INIT
// BEHAVIOUR
//  Reset: state=IDLE, s[287:0]=0, round counter=0; cfg_rdy=0, din_rdy=0, dout=0, dout_vld=0, BSY=0.
//  cfg_rdy = EN & (state==IDLE | state==RUN). Low in INIT and while RST is asserted.
//  Load on cfg handshake:
//   - s[79:0] = byte-reversed Kin, i.e. s[79:72]=Kin[7:0] ... s[7:0]=Kin[79:72].
//   - s[172:93] = byte-reversed Din, same rule.
//   - s[287:285]=3'b111; all other bits 0.
//   - dout_vld cleared; a pending output word is discarded.
//   - Next state INIT; the load is fully accepted in RUN as well (reload/rekey).
//  One round, computed combinationally W times in series per cycle:
//   - t1=s65^s92, t2=s161^s176, t3=s242^s287; z=t1^t2^t3
//   - t1^=s90&s91^s170; t2^=s174&s175^s263; t3^=s285&s286^s68
//   - s <= {s[286:177],t2,s[175:93],t1,s[91:0],t3}
//  FSM:
//   - IDLE: waits for a cfg handshake.
//   - INIT: advances W rounds per enabled cycle with z discarded; BSY=1.
//     After INIT_RND/W cycles the counter clears and the state moves to RUN.
//   - RUN: produces a word only into a free slot, i.e. when !dout_vld | dout_rdy.
//     That cycle advances W rounds and registers the word, so a single register gives a 1-word/cycle throughput.
//     The state never advances without producing a word, so no keystream is skipped.
//  Bit order: the earliest keystream bit of a word goes in dout[W-1], the latest in dout[0].
//  dout/dout_vld are held stable while dout_vld & !dout_rdy.
//  RST mid-INIT or mid-RUN returns the block to the reset values on the next edge; the key is not retained.
//  cfg handshake and output production in the same RUN cycle: the load wins, and no word is produced that cycle.
//  EN=0 in any state freezes the FSM, the counter, s, dout and dout_vld. Handshakes are evaluated only when EN=1.
// CONFIGURATION
//  TRIVIUM_XOR_EN defined:
//   - din_rdy = EN & state==RUN & (!dout_vld | dout_rdy).
//   - A word is produced only on a din handshake; dout = z_word ^ din.
//  TRIVIUM_XOR_EN undefined:
//   - din and din_vld are ignored; din_rdy is tied to 0.
//   - Words are produced whenever the slot is free; dout = z_word.
// TESTING
//  W=8, reset, cfg handshake -> BSY high exactly 144 cycles, then dout_vld=1 on the next cycle; cfg_rdy=0 throughout INIT.
//  W=1 and W=64 with the same key/IV, 512 bits each -> bitstreams identical and equal to the C golden model for eSTREAM set 1, vectors 0 and 1.
//  dout_rdy toggled randomly at 50% for 1000 words -> no word lost or duplicated; dout stable while stalled; concatenated output equals the model stream.
//  TRIVIUM_XOR_EN, encrypt 256 bytes, reload the same key/IV, feed ciphertext -> plaintext recovered exactly.
//  RST pulsed at INIT cycle 70, then cfg_vld at RUN word 10 -> state IDLE after RST and dout_vld=0.
//   After the new cfg: INIT restarts, the old pending word is dropped, and the first new word matches the model.
//  EN held low for 20 cycles mid-INIT and mid-RUN -> total INIT length still 144 enabled cycles; output stream unchanged.

Source files
------------

// File: rtl/trivium_stream_core.sv
// Trivium keystream engine: key/IV load, INIT_RND-round warm-up, then W keystream bits per clock.
// Define TRIVIUM_XOR_EN to XOR the din stream into the keystream (encrypt/decrypt datapath).
module trivium_stream_core #(
    parameter int W        = 8,
    parameter int INIT_RND = 1152
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [79:0]  Kin,
    input  logic [79:0]  Din,
    input  logic         cfg_vld,
    output logic         cfg_rdy,
    input  logic [W-1:0] din,
    input  logic         din_vld,
    output logic         din_rdy,
    output logic [W-1:0] dout,
    output logic         dout_vld,
    input  logic         dout_rdy,
    output logic         BSY,
    output logic [1:0]   dbg_state_o
);

    localparam int NCYC = INIT_RND / W;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

    if (!(W == 1 || W == 2 || W == 4 || W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
        $error("trivium_stream_core: W=%0d must be one of 1,2,4,8,16,32,64", W);
    end
    if ((INIT_RND % W) != 0) begin : g_bad_rnd
        $error("trivium_stream_core: INIT_RND=%0d is not a multiple of W=%0d", INIT_RND, W);
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [287:0]  s_q, s_d, s_adv, s_load;
    logic [288:0]  step;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  z_word, word_in, dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          cfg_fire, slot_free, word_go;

    // One Trivium round: returns {z, next state}.
    function automatic logic [288:0] trivium_round(input logic [287:0] s);
        logic t1, t2, t3, z;
        t1 = s[65] ^ s[92];
        t2 = s[161] ^ s[176];
        t3 = s[242] ^ s[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[90] & s[91]) ^ s[170];
        t2 = t2 ^ (s[174] & s[175]) ^ s[263];
        t3 = t3 ^ (s[285] & s[286]) ^ s[68];
        return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    // W rounds chained; the earliest keystream bit lands in the MSB.
    always_comb begin
        s_adv  = s_q;
        z_word = '0;
        step   = '0;
        for (int i = 0; i < W; i++) begin
            step              = trivium_round(s_adv);
            z_word[W-1-i]     = step[288];
            s_adv             = step[287:0];
        end
    end

    always_comb begin
        s_load = '0;
        for (int b = 0; b < 10; b++) begin
            s_load[8*b +: 8]      = Kin[72-8*b +: 8];
            s_load[93+8*b +: 8]   = Din[72-8*b +: 8];
        end
        s_load[287:285] = 3'b111;
    end

    // Valid/ready: a transfer happens on a rising CLK edge where EN & valid & ready;
    // valid may not depend on ready, and dout/dout_vld hold while dout_vld & !dout_rdy.
    assign cfg_rdy   = EN & !RST & ((state_q == ST_IDLE) | (state_q == ST_RUN));
    assign cfg_fire  = cfg_vld & cfg_rdy;
    assign slot_free = !vld_q | dout_rdy;

`ifdef TRIVIUM_XOR_EN
    // din is not taken on a reload cycle, since the reload suppresses the word it would feed.
    assign din_rdy = EN & !RST & (state_q == ST_RUN) & slot_free & !cfg_vld;
    assign word_go = din_vld & din_rdy;
    assign word_in = z_word ^ din;
`else
    logic unused_din;
    assign unused_din = ^{din, din_vld};
    assign din_rdy    = 1'b0;
    assign word_go    = (state_q == ST_RUN) & slot_free & !cfg_fire;
    assign word_in    = z_word;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        vld_d   = vld_q & !dout_rdy;
        if (cfg_fire) begin
            state_d = ST_INIT;
            s_d     = s_load;
            cnt_d   = '0;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    s_d = s_adv;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (word_go) begin
                        s_d    = s_adv;
                        dout_d = word_in;
                        vld_d  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else if (EN) begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    assign dout        = dout_q;
    assign dout_vld    = vld_q;
    assign BSY         = (state_q == ST_INIT);
    assign dbg_state_o = state_q;

endmodule
